seg_timing_ctrl: RTL and testbench

SEG_TIMING_CTRL -- requirements
Module: seg_timing_ctrl

---
 rtl/seg_timing_ctrl_if.sv | 30 +++
 rtl/seg_timing_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_seg_timing_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_timing_ctrl_if.sv
// Control/status bundle for seg_timing_ctrl: segment switch requests in, playback position out.
interface seg_timing_ctrl_if #(
  parameter int NUM_SEGMENTS = 4,
  parameter int CYCLE_WIDTH  = 16,
  parameter int SEG_WIDTH    = $clog2(NUM_SEGMENTS)
);
  logic                             set;
  logic [SEG_WIDTH-1:0]             req_segment;
  logic                             deferred;
  logic [NUM_SEGMENTS*CYCLE_WIDTH-1:0] cycle_in;
  logic [NUM_SEGMENTS*32-1:0]       freq_div_in;
  logic [31:0]                      rep;
  logic [SEG_WIDTH-1:0]             segment;
  logic [CYCLE_WIDTH-1:0]           idx;
  logic                             step;
  logic                             update;
  logic                             pending;
  logic                             stop;
  logic [15:0]                      switch_cnt;

  modport master (
    output set, req_segment, deferred, cycle_in, freq_div_in, rep,
    input  segment, idx, step, update, pending, stop, switch_cnt
  );

  modport slave (
    input  set, req_segment, deferred, cycle_in, freq_div_in, rep,
    output segment, idx, step, update, pending, stop, switch_cnt
  );
endinterface

// File: rtl/seg_timing_ctrl.sv
// Segment playback timer: steps IDX through the active segment's loop, switching immediately or at loop end.
// Optional macro SEG_TIMING_CTRL_SWITCH_CNT_EN enables the saturating completed-switch counter.
module seg_timing_ctrl #(
  parameter int NUM_SEGMENTS = 4,
  parameter int CYCLE_WIDTH  = 16,
  parameter int SEG_WIDTH    = $clog2(NUM_SEGMENTS)
) (
  input logic              clk,
  input logic              rst_n,
  seg_timing_ctrl_if.slave bus
);
  localparam logic [31:0] REP_INF = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_RUN     = 2'd1,
    ST_WAIT    = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [SEG_WIDTH-1:0]   seg_q, seg_d;
  logic [CYCLE_WIDTH-1:0] idx_q, idx_d;
  logic [31:0]            tick_q, tick_d;
  logic [31:0]            loop_q, loop_d;
  logic                   step_q, step_d;
  logic                   update_q, update_d;
  logic [CYCLE_WIDTH-1:0] act_cycle_q, act_cycle_d;
  logic [31:0]            act_div_q, act_div_d;
  logic [31:0]            act_rep_q, act_rep_d;
  logic [SEG_WIDTH-1:0]   req_seg_q, req_seg_d;
  logic [CYCLE_WIDTH-1:0] req_cycle_q, req_cycle_d;
  logic [31:0]            req_div_q, req_div_d;
  logic [31:0]            req_rep_q, req_rep_d;

  logic                   set_ok;
  logic [CYCLE_WIDTH-1:0] in_cycle;
  logic [31:0]            in_div;
  logic                   tick_wrap;
  logic                   loop_end;

  function automatic logic [31:0] eff_div(input logic [31:0] d);
    return (d == 32'd0) ? 32'd1 : d;
  endfunction

  // A selector matching no configured segment leaves set_ok low, so the SET is dropped.
  always_comb begin
    set_ok   = 1'b0;
    in_cycle = '0;
    in_div   = 32'd1;
    for (int k = 0; k < NUM_SEGMENTS; k++) begin
      if (bus.req_segment == SEG_WIDTH'(k)) begin
        set_ok   = bus.set;
        in_cycle = bus.cycle_in[k*CYCLE_WIDTH +: CYCLE_WIDTH];
        in_div   = eff_div(bus.freq_div_in[k*32 +: 32]);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    seg_d       = seg_q;
    idx_d       = idx_q;
    tick_d      = tick_q;
    loop_d      = loop_q;
    step_d      = 1'b0;
    update_d    = 1'b0;
    act_cycle_d = act_cycle_q;
    act_div_d   = act_div_q;
    act_rep_d   = act_rep_q;
    req_seg_d   = req_seg_q;
    req_cycle_d = req_cycle_q;
    req_div_d   = req_div_q;
    req_rep_d   = req_rep_q;
    tick_wrap   = (tick_q == act_div_q - 32'd1);
    loop_end    = tick_wrap && (idx_q == act_cycle_q);

    if (state_q != ST_STOPPED) begin
      if (!tick_wrap) begin
        tick_d = tick_q + 32'd1;
      end else begin
        tick_d = 32'd0;
        step_d = 1'b1;
        if (!loop_end) begin
          idx_d = idx_q + CYCLE_WIDTH'(1);
        end else if (state_q == ST_WAIT && !set_ok) begin
          state_d     = ST_RUN;
          seg_d       = req_seg_q;
          act_cycle_d = req_cycle_q;
          act_div_d   = req_div_q;
          act_rep_d   = req_rep_q;
          idx_d       = '0;
          loop_d      = 32'd0;
          update_d    = 1'b1;
        end else if (state_q == ST_RUN && !set_ok &&
                     act_rep_q != REP_INF && loop_q == act_rep_q) begin
          // Final loop done: IDX stays parked on the last sample.
          state_d = ST_STOPPED;
          step_d  = 1'b0;
        end else begin
          idx_d  = '0;
          loop_d = loop_q + 32'd1;
        end
      end
    end

    // A new request outranks whatever the loop end would have done this cycle.
    if (set_ok) begin
      req_seg_d   = bus.req_segment;
      req_cycle_d = in_cycle;
      req_div_d   = in_div;
      req_rep_d   = bus.rep;
      if (!bus.deferred || state_q == ST_STOPPED) begin
        state_d     = ST_RUN;
        seg_d       = bus.req_segment;
        act_cycle_d = in_cycle;
        act_div_d   = in_div;
        act_rep_d   = bus.rep;
        idx_d       = '0;
        tick_d      = 32'd0;
        loop_d      = 32'd0;
        step_d      = 1'b0;
        update_d    = 1'b1;
      end else begin
        state_d = ST_WAIT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_STOPPED;
      seg_q       <= '0;
      idx_q       <= '0;
      tick_q      <= 32'd0;
      loop_q      <= 32'd0;
      step_q      <= 1'b0;
      update_q    <= 1'b0;
      act_cycle_q <= '0;
      act_div_q   <= 32'd0;
      act_rep_q   <= 32'd0;
      req_seg_q   <= '0;
      req_cycle_q <= '0;
      req_div_q   <= 32'd0;
      req_rep_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      seg_q       <= seg_d;
      idx_q       <= idx_d;
      tick_q      <= tick_d;
      loop_q      <= loop_d;
      step_q      <= step_d;
      update_q    <= update_d;
      act_cycle_q <= act_cycle_d;
      act_div_q   <= act_div_d;
      act_rep_q   <= act_rep_d;
      req_seg_q   <= req_seg_d;
      req_cycle_q <= req_cycle_d;
      req_div_q   <= req_div_d;
      req_rep_q   <= req_rep_d;
    end
  end

`ifdef SEG_TIMING_CTRL_SWITCH_CNT_EN
  logic [15:0] switch_cnt_q, switch_cnt_d;

  always_comb begin
    switch_cnt_d = switch_cnt_q;
    if (update_d && switch_cnt_q != 16'hFFFF) begin
      switch_cnt_d = switch_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      switch_cnt_q <= 16'd0;
    end else begin
      switch_cnt_q <= switch_cnt_d;
    end
  end

  assign bus.switch_cnt = switch_cnt_q;
`else
  assign bus.switch_cnt = 16'd0;
`endif

  assign bus.segment = seg_q;
  assign bus.idx     = idx_q;
  assign bus.step    = step_q;
  assign bus.update  = update_q;
  assign bus.pending = (state_q == ST_WAIT);
  assign bus.stop    = (state_q == ST_STOPPED);
endmodule

// File: tb/tb_seg_timing_ctrl.sv
// Self-checking bench for seg_timing_ctrl: directed scenarios plus randomized traffic against a position-arithmetic model.
module tb_seg_timing_ctrl;
  localparam int          NSEG = 4;
  localparam int          CW   = 16;
  localparam int          SW   = 3;
  localparam logic [31:0] INF  = 32'hFFFF_FFFF;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seg_timing_ctrl_if #(.NUM_SEGMENTS(NSEG), .CYCLE_WIDTH(CW), .SEG_WIDTH(SW)) bus ();

  seg_timing_ctrl #(.NUM_SEGMENTS(NSEG), .CYCLE_WIDTH(CW), .SEG_WIDTH(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Model: position derived from cycles elapsed since the last switch.
  int          m_mode;  // 0 stopped, 1 running, 2 waiting
  int          m_seg, m_cycle, m_div, p_seg, p_cycle, p_div;
  logic [31:0] m_rep, p_rep;
  longint      m_c0, edge_n;
  int          e_idx;
  bit          e_step, e_update;

  task automatic model_reset();
    m_mode = 0; m_seg = 0; m_cycle = 0; m_div = 1; m_rep = 0;
    p_seg = 0; p_cycle = 0; p_div = 1; p_rep = 0;
    m_c0 = 0; edge_n = 0; e_idx = 0; e_step = 0; e_update = 0;
  endtask

  task automatic model_edge(input bit s, input int seg, input bit def, input int cyc,
                            input int div, input logic [31:0] rep);
    bit     sv;
    longint t, n, len;
    bit     stp, lend;
    sv = s && (seg < NSEG);
    edge_n++;
    e_update = 0;
    e_step   = 0;
    if (m_mode != 0) begin
      t    = edge_n - m_c0;
      len  = longint'(m_cycle) + 1;
      n    = t / m_div;
      stp  = (t % m_div) == 0;
      lend = stp && (n % len == 0);
      e_step = stp;
      e_idx  = int'(n % len);
      if (lend && !sv && m_mode == 2) begin
        m_mode = 1; m_seg = p_seg; m_cycle = p_cycle; m_div = p_div; m_rep = p_rep;
        m_c0 = edge_n; e_idx = 0; e_update = 1;
      end else if (lend && !sv && m_mode == 1 && m_rep != INF &&
                   (n / len) == longint'(m_rep) + 1) begin
        m_mode = 0; e_step = 0; e_idx = m_cycle;
      end
    end
    if (sv) begin
      p_seg = seg; p_cycle = cyc; p_div = (div == 0) ? 1 : div; p_rep = rep;
      if (!def || m_mode == 0) begin
        m_mode = 1; m_seg = p_seg; m_cycle = p_cycle; m_div = p_div; m_rep = p_rep;
        m_c0 = edge_n; e_idx = 0; e_step = 0; e_update = 1;
      end else begin
        m_mode = 2;
      end
    end
  endtask

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  // Unselected slices carry random junk so only the sampled slice matters.
  task automatic drive(input bit s, input int seg, input bit def, input int cyc,
                       input int div, input logic [31:0] rep);
    bus.set         = s;
    bus.req_segment = SW'(seg);
    bus.deferred    = def;
    bus.rep         = rep;
    bus.cycle_in    = {$urandom, $urandom};
    bus.freq_div_in = {$urandom, $urandom, $urandom, $urandom};
    if (seg < NSEG) begin
      bus.cycle_in[seg*CW +: CW]    = CW'(cyc);
      bus.freq_div_in[seg*32 +: 32] = 32'(div);
    end
  endtask

  task automatic noise();
    drive(1'b0, int'($urandom % NSEG), 1'($urandom), int'($urandom % 8), int'($urandom % 4), $urandom);
  endtask

  task automatic do_reset();
    noise();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    drive(1'b1, 2, 1'b0, 3, 1, INF);
    clk_step();
    noise();
    clk_step();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.stop !== 1'b1) begin errors++; $display("FAIL reset_stop got %0b exp 1", bus.stop); end
    checks++; if (bus.segment !== 3'd0) begin errors++; $display("FAIL reset_segment got %0d exp 0", bus.segment); end
    checks++; if (bus.idx !== 16'd0) begin errors++; $display("FAIL reset_idx got %0d exp 0", bus.idx); end
    checks++; if ({bus.step, bus.update, bus.pending} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b exp 000", {bus.step, bus.update, bus.pending}); end
    checks++; if (bus.switch_cnt !== 16'd0) begin errors++; $display("FAIL reset_switch_cnt got %0d exp 0", bus.switch_cnt); end
    drive(1'b1, 1, 1'b0, 3, 1, INF);
    clk_step();
    checks++; if (bus.stop !== 1'b1 || bus.update !== 1'b0) begin errors++; $display("FAIL reset_hold stop %0b update %0b exp 1 0", bus.stop, bus.update); end
    noise();
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_basic();
    do_reset();
    drive(1'b1, 1, 1'b0, 3, 2, 32'd1);
    clk_step();
    checks++; if (bus.update !== 1'b1 || bus.segment !== 3'd1 || bus.idx !== 16'd0 || bus.step !== 1'b0 || bus.stop !== 1'b0)
      begin errors++; $display("FAIL basic_switch upd %0b seg %0d idx %0d step %0b stop %0b exp 1 1 0 0 0", bus.update, bus.segment, bus.idx, bus.step, bus.stop); end
    for (int t = 1; t < 16; t++) begin
      noise();
      clk_step();
      checks++; if (bus.idx !== 16'((t / 2) % 4) || bus.step !== 1'((t % 2) == 0) || bus.update !== 1'b0 || bus.stop !== 1'b0)
        begin errors++; $display("FAIL basic_run t %0d idx %0d step %0b upd %0b stop %0b exp idx %0d step %0b", t, bus.idx, bus.step, bus.update, bus.stop, (t / 2) % 4, (t % 2) == 0); end
    end
    for (int t = 16; t < 19; t++) begin
      noise();
      clk_step();
      checks++; if (bus.stop !== 1'b1 || bus.idx !== 16'd3 || bus.step !== 1'b0)
        begin errors++; $display("FAIL basic_stopped t %0d stop %0b idx %0d step %0b exp 1 3 0", t, bus.stop, bus.idx, bus.step); end
    end
  endtask

  task automatic test_deferred();
    do_reset();
    drive(1'b1, 0, 1'b0, 7, 1, INF);
    clk_step();
    noise(); clk_step(); clk_step();
    checks++; if (bus.idx !== 16'd2) begin errors++; $display("FAIL defer_pre idx %0d exp 2", bus.idx); end
    drive(1'b1, 2, 1'b1, 4, 1, INF);
    clk_step();
    for (int t = 3; t < 8; t++) begin
      checks++; if (bus.pending !== 1'b1 || bus.segment !== 3'd0 || bus.idx !== 16'(t) || bus.update !== 1'b0)
        begin errors++; $display("FAIL defer_wait t %0d pend %0b seg %0d idx %0d upd %0b exp 1 0 %0d 0", t, bus.pending, bus.segment, bus.idx, bus.update, t); end
      noise();
      clk_step();
    end
    checks++; if (bus.segment !== 3'd2 || bus.idx !== 16'd0 || bus.update !== 1'b1 || bus.step !== 1'b1 || bus.pending !== 1'b0)
      begin errors++; $display("FAIL defer_switch seg %0d idx %0d upd %0b step %0b pend %0b exp 2 0 1 1 0", bus.segment, bus.idx, bus.update, bus.step, bus.pending); end
    clk_step();
    checks++; if (bus.segment !== 3'd2 || bus.idx !== 16'd1 || bus.update !== 1'b0)
      begin errors++; $display("FAIL defer_after seg %0d idx %0d upd %0b exp 2 1 0", bus.segment, bus.idx, bus.update); end
  endtask

  task automatic test_wait_immediate();
    drive(1'b1, 1, 1'b1, 2, 1, INF);
    clk_step();
    checks++; if (bus.pending !== 1'b1) begin errors++; $display("FAIL waitimm_pend got %0b exp 1", bus.pending); end
    noise();
    clk_step();
    drive(1'b1, 3, 1'b0, 1, 1, INF);
    clk_step();
    checks++; if (bus.segment !== 3'd3 || bus.idx !== 16'd0 || bus.pending !== 1'b0 || bus.update !== 1'b1)
      begin errors++; $display("FAIL waitimm_switch seg %0d idx %0d pend %0b upd %0b exp 3 0 0 1", bus.segment, bus.idx, bus.pending, bus.update); end
    for (int t = 1; t < 7; t++) begin
      noise();
      clk_step();
      checks++; if (bus.segment !== 3'd3 || bus.idx !== 16'(t % 2) || bus.update !== 1'b0 || bus.pending !== 1'b0)
        begin errors++; $display("FAIL waitimm_run t %0d seg %0d idx %0d upd %0b pend %0b exp 3 %0d 0 0", t, bus.segment, bus.idx, bus.update, bus.pending, t % 2); end
    end
  endtask

  task automatic test_invalid_div0();
    do_reset();
    drive(1'b1, 5, 1'b0, 3, 1, 32'd0);
    clk_step();
    checks++; if (bus.stop !== 1'b1 || bus.segment !== 3'd0 || bus.idx !== 16'd0 || bus.update !== 1'b0)
      begin errors++; $display("FAIL invalid_stopped stop %0b seg %0d idx %0d upd %0b exp 1 0 0 0", bus.stop, bus.segment, bus.idx, bus.update); end
    drive(1'b1, 0, 1'b0, 5, 0, INF);
    clk_step();
    for (int t = 1; t < 6; t++) begin
      noise();
      clk_step();
      checks++; if (bus.step !== 1'b1 || bus.idx !== 16'(t))
        begin errors++; $display("FAIL div0_step t %0d step %0b idx %0d exp 1 %0d", t, bus.step, bus.idx, t); end
    end
    drive(1'b1, 5, 1'b0, 2, 1, 32'd0);
    clk_step();
    checks++; if (bus.idx !== 16'd0 || bus.step !== 1'b1 || bus.update !== 1'b0 || bus.segment !== 3'd0)
      begin errors++; $display("FAIL invalid_running idx %0d step %0b upd %0b seg %0d exp 0 1 0 0", bus.idx, bus.step, bus.update, bus.segment); end
  endtask

  task automatic test_set_at_loop_end();
    do_reset();
    drive(1'b1, 0, 1'b0, 1, 1, 32'd0);
    clk_step();
    noise();
    clk_step();
    drive(1'b1, 1, 1'b1, 2, 1, INF);
    clk_step();
    checks++; if (bus.stop !== 1'b0 || bus.pending !== 1'b1 || bus.idx !== 16'd0 || bus.step !== 1'b1)
      begin errors++; $display("FAIL prio_loopend stop %0b pend %0b idx %0d step %0b exp 0 1 0 1", bus.stop, bus.pending, bus.idx, bus.step); end
    noise(); clk_step(); clk_step();
    checks++; if (bus.segment !== 3'd1 || bus.update !== 1'b1 || bus.pending !== 1'b0)
      begin errors++; $display("FAIL prio_switch seg %0d upd %0b pend %0b exp 1 1 0", bus.segment, bus.update, bus.pending); end
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    drive(1'b1, 1, 1'b0, 3, 1, INF);
    clk_step();
    drive(1'b1, 2, 1'b1, 1, 1, INF);
    clk_step();
    checks++; if (bus.pending !== 1'b1) begin errors++; $display("FAIL rstwait_pend got %0b exp 1", bus.pending); end
    noise();
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({bus.stop, bus.pending, bus.step, bus.update} !== 4'b1000 || bus.segment !== 3'd0 || bus.idx !== 16'd0)
      begin errors++; $display("FAIL rstwait_in_reset stop/pend/step/upd %b seg %0d idx %0d exp 1000 0 0", {bus.stop, bus.pending, bus.step, bus.update}, bus.segment, bus.idx); end
    clk_step();
    rst_n = 1'b1;
    for (int t = 0; t < 8; t++) begin
      noise();
      clk_step();
      checks++; if (bus.stop !== 1'b1 || bus.update !== 1'b0 || bus.segment !== 3'd0 || bus.pending !== 1'b0)
        begin errors++; $display("FAIL rstwait_after t %0d stop %0b upd %0b seg %0d pend %0b exp 1 0 0 0", t, bus.stop, bus.update, bus.segment, bus.pending); end
    end
    model_reset();
  endtask

  task automatic test_switch_cnt();
    int exp_cnt;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, k, 1'b0, 2, 1, INF);
      clk_step();
`ifdef SEG_TIMING_CTRL_SWITCH_CNT_EN
      exp_cnt = k + 1;
`else
      exp_cnt = 0;
`endif
      checks++; if (bus.switch_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL switch_cnt after %0d switches got %0d exp %0d", k + 1, bus.switch_cnt, exp_cnt); end
    end
  endtask

  task automatic test_random();
    bit          s, def;
    int          seg, cyc, div;
    logic [31:0] rep;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      s   = ($urandom % 6) == 0;
      seg = int'($urandom % 6);
      def = 1'($urandom);
      cyc = int'($urandom % 5);
      div = int'($urandom % 4);
      rep = (($urandom % 4) == 0) ? INF : 32'($urandom % 3);
      drive(s, seg, def, cyc, div, rep);
      model_edge(s, seg, def, cyc, div, rep);
      clk_step();
      checks++; if (bus.segment !== SW'(m_seg)) begin errors++; $display("FAIL rnd_segment cyc %0d got %0d exp %0d", i, bus.segment, m_seg); end
      checks++; if (bus.idx !== CW'(e_idx)) begin errors++; $display("FAIL rnd_idx cyc %0d got %0d exp %0d", i, bus.idx, e_idx); end
      checks++; if (bus.step !== e_step) begin errors++; $display("FAIL rnd_step cyc %0d got %0b exp %0b", i, bus.step, e_step); end
      checks++; if (bus.update !== e_update) begin errors++; $display("FAIL rnd_update cyc %0d got %0b exp %0b", i, bus.update, e_update); end
      checks++; if (bus.pending !== (m_mode == 2)) begin errors++; $display("FAIL rnd_pending cyc %0d got %0b exp %0b", i, bus.pending, m_mode == 2); end
      checks++; if (bus.stop !== (m_mode == 0)) begin errors++; $display("FAIL rnd_stop cyc %0d got %0b exp %0b", i, bus.stop, m_mode == 0); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_deferred();
    test_wait_immediate();
    test_invalid_div0();
    test_set_at_loop_end();
    test_reset_in_wait();
    test_switch_cnt();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
